// File: rtl/psc_trigger_pkg.sv
// Shared types and default frame constants for the PSC trigger serializer.
package psc_trigger_pkg;

    // Content of the frame currently being shifted out on a channel
    typedef enum logic {
        FT_IDLE = 1'b0,
        FT_TRIG = 1'b1
    } frame_type_t;

    localparam int PSC_FRAME_W_DEF = 100;

    // Frames are sent bit 0 first: idle is 1,0,1,0..., trigger is 0,1,1,0...
    localparam logic [PSC_FRAME_W_DEF-1:0] PSC_IDLE_PATTERN_DEF = {25{4'h5}};
    localparam logic [PSC_FRAME_W_DEF-1:0] PSC_TRIG_PATTERN_DEF = {25{4'h6}};

endpackage

// File: rtl/psc_trigger_channel.sv
// One PSC trigger link: input synchroniser, rising-edge detector, trigger
// queue counter, sticky overflow flag and the registered serial output.
module psc_trigger_channel
    import psc_trigger_pkg::*;
#(
    parameter int                 FRAME_W      = PSC_FRAME_W_DEF,
    parameter logic [FRAME_W-1:0] IDLE_PATTERN = PSC_IDLE_PATTERN_DEF,
    parameter logic [FRAME_W-1:0] TRIG_PATTERN = PSC_TRIG_PATTERN_DEF,
    parameter int                 QUEUE_DEPTH  = 3,
    parameter int                 SYNC_STAGES  = 2,
    localparam int                BIT_W        = $clog2(FRAME_W)
) (
    input  logic             pll_clock,
    input  logic             reset,
    input  logic             evr_trigger,
    input  logic             ch_enable,
    input  logic             clear_overflow,
    input  logic [BIT_W-1:0] bit_idx_next,
    input  logic             frame_last,
    output logic             psc_output,
    output logic             busy,
    output logic             overflow
);

    localparam int               PEND_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PEND_W-1:0] Q_MAX = PEND_W'(QUEUE_DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   edge_pulse;

    logic [PEND_W-1:0] pending, pending_next;
    frame_type_t       frame_type, frame_type_next;
    logic              inc, launch, drop;
    logic              overflow_next, out_next, busy_next;

    // Resynchronise the asynchronous trigger and register a one-cycle rising-edge pulse
    always_ff @(posedge pll_clock or negedge reset) begin
        if (!reset) begin
            sync       <= '0;
            sync_prev  <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], evr_trigger};
            sync_prev  <= sync[SYNC_STAGES-1];
            edge_pulse <= sync[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // Queue bookkeeping, frame selection and the next serial bit
    always_comb begin
        inc             = edge_pulse & ch_enable;
        // A trigger arriving on the last bit with an empty queue goes straight out
        launch          = frame_last & ch_enable & ((pending != '0) | inc);
        drop            = inc & ~launch & (pending == Q_MAX);
        pending_next    = pending;
        overflow_next   = overflow;
        frame_type_next = frame_type;

        if (!ch_enable) begin
            pending_next = '0;
        end else if (!drop) begin
            pending_next = pending + PEND_W'(inc) - PEND_W'(launch);
        end

        if (drop) begin
            overflow_next = 1'b1;
        end else if (clear_overflow) begin
            overflow_next = 1'b0;
        end

        // Frame content only changes at a frame boundary, so a frame in flight is never cut short
        if (frame_last) begin
            frame_type_next = launch ? FT_TRIG : FT_IDLE;
        end

        out_next  = (frame_type_next == FT_TRIG) ? TRIG_PATTERN[bit_idx_next]
                                                 : IDLE_PATTERN[bit_idx_next];
        busy_next = (frame_type_next == FT_TRIG) | (pending_next != '0);
    end

    // Channel state and registered outputs
    always_ff @(posedge pll_clock or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            overflow   <= 1'b0;
            frame_type <= FT_IDLE;
            psc_output <= IDLE_PATTERN[0];
            busy       <= 1'b0;
        end else begin
            pending    <= pending_next;
            overflow   <= overflow_next;
            frame_type <= frame_type_next;
            psc_output <= out_next;
            busy       <= busy_next;
        end
    end

endmodule

// File: rtl/psc_trigger_serializer.sv
// Multi-channel PSC trigger transmitter: one shared frame bit counter drives
// N_CH independent serial trigger channels.
module psc_trigger_serializer
    import psc_trigger_pkg::*;
#(
    parameter int                 N_CH         = 4,
    parameter int                 FRAME_W      = PSC_FRAME_W_DEF,
    parameter logic [FRAME_W-1:0] IDLE_PATTERN = PSC_IDLE_PATTERN_DEF,
    parameter logic [FRAME_W-1:0] TRIG_PATTERN = PSC_TRIG_PATTERN_DEF,
    parameter int                 QUEUE_DEPTH  = 3,
    parameter int                 SYNC_STAGES  = 2
) (
    input  logic            pll_clock,
    input  logic            reset,
    input  logic [N_CH-1:0] evr_trigger,
    input  logic [N_CH-1:0] ch_enable,
    input  logic [N_CH-1:0] clear_overflow,
    output logic [N_CH-1:0] psc_output,
    output logic            frame_start,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] overflow
);

    localparam int               BIT_W    = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(FRAME_W - 1);

    logic [BIT_W-1:0] bit_idx, bit_idx_next;
    logic             frame_last;

    // Next position in the shared frame, wrapping after the last bit
    always_comb begin
        frame_last   = (bit_idx == LAST_IDX);
        bit_idx_next = frame_last ? '0 : bit_idx + 1'b1;
    end

    // Shared frame timebase; frame_start marks bit 0 of every frame
    always_ff @(posedge pll_clock or negedge reset) begin
        if (!reset) begin
            bit_idx     <= '0;
            frame_start <= 1'b1;
        end else begin
            bit_idx     <= bit_idx_next;
            frame_start <= (bit_idx_next == '0);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        psc_trigger_channel #(
            .FRAME_W      (FRAME_W),
            .IDLE_PATTERN (IDLE_PATTERN),
            .TRIG_PATTERN (TRIG_PATTERN),
            .QUEUE_DEPTH  (QUEUE_DEPTH),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .pll_clock      (pll_clock),
            .reset          (reset),
            .evr_trigger    (evr_trigger[c]),
            .ch_enable      (ch_enable[c]),
            .clear_overflow (clear_overflow[c]),
            .bit_idx_next   (bit_idx_next),
            .frame_last     (frame_last),
            .psc_output     (psc_output[c]),
            .busy           (busy[c]),
            .overflow       (overflow[c])
        );
    end

endmodule
